// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for the 5-stage MIPS pipeline (F/D/E/M/W).
// Optional feature macro HAZARD_MD_EN: mult/div decode, busy counter and md stalls.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_instr,
  output logic        stall,
  output logic [1:0]  fwd_D_rs,
  output logic [1:0]  fwd_D_rt,
  output logic [1:0]  fwd_E_rs,
  output logic [1:0]  fwd_E_rt,
  output logic [1:0]  fwd_M_rt,
  output logic        md_busy
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = D_instr[31:26];
  assign rs = D_instr[25:21];
  assign rt = D_instr[20:16];
  assign rd = D_instr[15:11];
  assign fn = D_instr[5:0];

  logic [4:0] d_a3;
  logic [1:0] d_tnew, rs_tuse, rt_tuse;
  logic       md_stall;

`ifdef HAZARD_MD_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [1:0] MD_NONE  = 2'd0;
  localparam logic [1:0] MD_MULT  = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam int CNT_W = $clog2(((DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC) + 1);

  logic             d_md_op;
  logic [1:0]       d_md_start, e_md_d, e_md_q;
  logic [CNT_W-1:0] md_cnt_d, md_cnt_q;
`endif

  always_comb begin : decode
    d_a3    = 5'd0;
    d_tnew  = 2'd0;
    rs_tuse = TUSE_NONE;
    rt_tuse = TUSE_NONE;
`ifdef HAZARD_MD_EN
    d_md_op    = 1'b0;
    d_md_start = MD_NONE;
`endif
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            rs_tuse = 2'd1; rt_tuse = 2'd1; d_a3 = rd; d_tnew = 2'd1;
          end
          FN_JR: rs_tuse = 2'd0;
`ifdef HAZARD_MD_EN
          FN_MULT, FN_MULTU: begin
            rs_tuse = 2'd1; rt_tuse = 2'd1; d_md_op = 1'b1; d_md_start = MD_MULT;
          end
          FN_DIV, FN_DIVU: begin
            rs_tuse = 2'd1; rt_tuse = 2'd1; d_md_op = 1'b1; d_md_start = MD_DIV;
          end
          FN_MFHI, FN_MFLO: begin
            d_a3 = rd; d_tnew = 2'd1; d_md_op = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            rs_tuse = 2'd1; d_md_op = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      OP_ORI: begin rs_tuse = 2'd1; d_a3 = rt; d_tnew = 2'd1; end
      OP_LUI: begin d_a3 = rt; d_tnew = 2'd1; end
      OP_LW:  begin rs_tuse = 2'd1; d_a3 = rt; d_tnew = 2'd2; end
      OP_SW:  begin rs_tuse = 2'd1; rt_tuse = 2'd2; end
      OP_BEQ: begin rs_tuse = 2'd0; rt_tuse = 2'd0; end
      OP_JAL: begin d_a3 = 5'd31; d_tnew = 2'd0; end
      default: ;
    endcase
  end

  logic [4:0] e_a3_d, e_a3_q, e_rs_d, e_rs_q, e_rt_d, e_rt_q;
  logic [1:0] e_tnew_d, e_tnew_q;
  logic [4:0] m_a3_d, m_a3_q, m_rt_d, m_rt_q, w_a3_d, w_a3_q;
  logic [1:0] m_tnew_d, m_tnew_q;

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                  input logic [4:0] m_a3, input logic [1:0] m_tnew);
    return (tuse != TUSE_NONE) && (src != 5'd0) &&
           (((src == e_a3) && (tuse < e_tnew)) || ((src == m_a3) && (tuse < m_tnew)));
  endfunction

  // Nearest producer wins; a producer still computing (Tnew>0) yields 0 and relies on stall.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                         input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                         input logic [4:0] w_a3);
    if (src == 5'd0) return 2'd0;
    if (src == e_a3) return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    if (src == m_a3) return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    if (src == w_a3) return 2'd3;
    return 2'd0;
  endfunction

  assign stall = hazard(rs, rs_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q) |
                 hazard(rt, rt_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q) |
                 md_stall;

  assign fwd_D_rs = fwd_sel(rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
  assign fwd_D_rt = fwd_sel(rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
  assign fwd_E_rs = fwd_sel(e_rs_q, 5'd0, 2'd0, m_a3_q, m_tnew_q, w_a3_q);
  assign fwd_E_rt = fwd_sel(e_rt_q, 5'd0, 2'd0, m_a3_q, m_tnew_q, w_a3_q);
  assign fwd_M_rt = fwd_sel(m_rt_q, 5'd0, 2'd0, 5'd0, 2'd0, w_a3_q);

  always_comb begin : pipe_next
    e_a3_d   = stall ? 5'd0 : d_a3;
    e_tnew_d = stall ? 2'd0 : d_tnew;
    e_rs_d   = stall ? 5'd0 : rs;
    e_rt_d   = stall ? 5'd0 : rt;
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    m_rt_d   = e_rt_q;
    w_a3_d   = m_a3_q;
  end

  // E/M/W boundary registers
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      m_rt_q   <= 5'd0;
      w_a3_q   <= 5'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
    end
  end

`ifdef HAZARD_MD_EN
  // A start sitting in E loads the counter; D-stage md ops wait until it drains.
  always_comb begin : md_next
    e_md_d = stall ? MD_NONE : d_md_start;
    if (e_md_q == MD_MULT)      md_cnt_d = CNT_W'(MULT_CYC);
    else if (e_md_q == MD_DIV)  md_cnt_d = CNT_W'(DIV_CYC);
    else if (md_cnt_q != '0)    md_cnt_d = md_cnt_q - CNT_W'(1);
    else                        md_cnt_d = md_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_q   <= MD_NONE;
      md_cnt_q <= '0;
    end else begin
      e_md_q   <= e_md_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = d_md_op && (md_busy || (e_md_q != MD_NONE));
`else
  logic unused_md_cfg;
  assign unused_md_cfg = ^{MULT_CYC, DIV_CYC};
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif

  logic unused_shamt;
  assign unused_shamt = ^D_instr[10:6];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-history reference model plus directed literal cases.
module tb_hazard_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] D_instr = 32'd0;
  logic        stall, md_busy;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .D_instr(D_instr), .stall(stall),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
    .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] rtype(input int s, input int t, input int d, input logic [5:0] f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
    return {o, 5'(s), 5'(t), imm};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int dest; int tnew; int rs; int rt; int rs_tuse; int rt_tuse; int md_cyc; bit md_op;
  } rec_t;

  function automatic rec_t decode(input logic [31:0] ins);
    rec_t r;
    int op, fn, rd;
    r = '{default:0};
    r.rs_tuse = 3; r.rt_tuse = 3;
    op = int'(ins[31:26]); fn = int'(ins[5:0]); rd = int'(ins[15:11]);
    r.rs = int'(ins[25:21]); r.rt = int'(ins[20:16]);
    case (op)
      0: begin
        if (fn == 'h21 || fn == 'h23) begin r.rs_tuse = 1; r.rt_tuse = 1; r.dest = rd; r.tnew = 1; end
        else if (fn == 'h08) r.rs_tuse = 0;
`ifdef HAZARD_MD_EN
        else if (fn >= 'h18 && fn <= 'h1b) begin
          r.rs_tuse = 1; r.rt_tuse = 1; r.md_op = 1; r.md_cyc = (fn <= 'h19) ? MULT_CYC : DIV_CYC;
        end
        else if (fn == 'h10 || fn == 'h12) begin r.dest = rd; r.tnew = 1; r.md_op = 1; end
        else if (fn == 'h11 || fn == 'h13) begin r.rs_tuse = 1; r.md_op = 1; end
`endif
      end
      'h0d: begin r.rs_tuse = 1; r.dest = r.rt; r.tnew = 1; end
      'h0f: begin r.dest = r.rt; r.tnew = 1; end
      'h23: begin r.rs_tuse = 1; r.dest = r.rt; r.tnew = 2; end
      'h2b: begin r.rs_tuse = 1; r.rt_tuse = 2; end
      'h04: begin r.rs_tuse = 0; r.rt_tuse = 0; end
      'h03: begin r.dest = 31; r.tnew = 0; end
      default: ;
    endcase
    return r;
  endfunction

  // hist[c % 64] = instruction record occupying E during cycle c; anything older than kill is flushed.
  rec_t hist[64];
  int   cyc  = 0;
  int   kill = 1 << 30;
  bit   last_stall = 1'b0;

  function automatic rec_t stage(input int k);
    rec_t b;
    b = '{default:0};
    if (cyc - k < kill) return b;
    return hist[(cyc - k) % 64];
  endfunction

  function automatic int sat_dec(input int t);
    return (t > 0) ? t - 1 : 0;
  endfunction

  function automatic bit model_busy();
    for (int k = 1; k <= DIV_CYC; k++)
      if (cyc - k >= kill && hist[(cyc - k) % 64].md_cyc >= k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hz(input int src, input int tuse);
    rec_t e, m;
    e = stage(0); m = stage(1);
    if (src == 0 || tuse >= 3) return 1'b0;
    return (src == e.dest && tuse < e.tnew) || (src == m.dest && tuse < sat_dec(m.tnew));
  endfunction

  function automatic bit model_stall(input logic [31:0] ins);
    rec_t r;
    r = decode(ins);
    return hz(r.rs, r.rs_tuse) || hz(r.rt, r.rt_tuse) ||
           (r.md_op && (model_busy() || stage(0).md_cyc != 0));
  endfunction

  // from: 0 = consumer in D (E,M,W visible), 1 = in E (M,W), 2 = in M (W only)
  function automatic int model_fwd(input int src, input int from);
    rec_t e, m, w;
    e = stage(0); m = stage(1); w = stage(2);
    if (src == 0) return 0;
    if (from == 0 && e.dest == src) return (e.tnew == 0) ? 1 : 0;
    if (from <= 1 && m.dest == src) return (sat_dec(m.tnew) == 0) ? 2 : 0;
    if (w.dest == src) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin : model_update
    rec_t nx;
    last_stall = model_stall(D_instr);
    if (reset || last_stall) nx = '{default:0};
    else nx = decode(D_instr);
    hist[(cyc + 1) % 64] = nx;
    if (reset) kill = cyc + 1;
    cyc++;
  end

  always @(negedge clk) begin : compare
    rec_t d;
    if (cyc >= kill) begin
      d = decode(D_instr);
      chk("stall",    32'(stall),    32'(model_stall(D_instr)));
      chk("fwd_D_rs", 32'(fwd_D_rs), 32'(model_fwd(d.rs, 0)));
      chk("fwd_D_rt", 32'(fwd_D_rt), 32'(model_fwd(d.rt, 0)));
      chk("fwd_E_rs", 32'(fwd_E_rs), 32'(model_fwd(stage(0).rs, 1)));
      chk("fwd_E_rt", 32'(fwd_E_rt), 32'(model_fwd(stage(0).rt, 1)));
      chk("fwd_M_rt", 32'(fwd_M_rt), 32'(model_fwd(stage(1).rt, 2)));
      chk("md_busy",  32'(md_busy),  32'(model_busy()));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] NOP = 32'd0;

  task automatic put(input logic [31:0] ins);
    @(posedge clk); #1;
    D_instr = ins;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic flush();
    repeat (4) put(NOP);
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    int s, t, d;
    logic [15:0] imm;
    s = rreg(); t = rreg(); d = rreg(); imm = 16'($urandom);
    case ($urandom_range(0, 19))
      0:  return rtype(s, t, d, 6'h21);
      1:  return rtype(s, t, d, 6'h23);
      2:  return itype(6'h0d, s, t, imm);
      3:  return itype(6'h0f, 0, t, imm);
      4:  return itype(6'h23, s, t, imm);
      5:  return itype(6'h2b, s, t, imm);
      6:  return itype(6'h04, s, t, imm);
      7:  return rtype(s, 0, 0, 6'h08);
      8:  return {6'h03, 26'($urandom)};
      9:  return {6'h02, 26'($urandom)};
      10: return NOP;
      11: return {6'h3f, 26'($urandom)};
      12: return rtype(s, t, 0, 6'h18);
      13: return rtype(s, t, 0, 6'h19);
      14: return rtype(s, t, 0, 6'h1a);
      15: return rtype(s, t, 0, 6'h1b);
      16: return rtype(0, 0, d, 6'h10);
      17: return rtype(0, 0, d, 6'h12);
      18: return rtype(s, 0, 0, 6'h11);
      default: return rtype(s, 0, 0, 6'h13);
    endcase
  endfunction

  initial begin : stim
    int n_st, n_bz;
    D_instr = rtype(1, 1, 2, 6'h21);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mid();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    flush();

    // lw $1 ; addu $2,$1,$1
    put(itype(6'h23, 0, 1, 16'd0)); mid();
    chk("lw_first_nostall", 32'(stall), 0);
    put(rtype(1, 1, 2, 6'h21)); mid();
    chk("lw_use_stall", 32'(stall), 1);
    put(rtype(1, 1, 2, 6'h21)); mid();
    chk("lw_use_release", 32'(stall), 0);
    chk("lw_use_D_rs", 32'(fwd_D_rs), 0);
    put(NOP); mid();
    chk("lw_use_E_rs", 32'(fwd_E_rs), 3);
    chk("lw_use_E_rt", 32'(fwd_E_rt), 3);
    flush();

    // ori $1,$0,5 ; beq $1,$0
    put(itype(6'h0d, 0, 1, 16'd5));
    put(itype(6'h04, 1, 0, 16'd4)); mid();
    chk("ori_beq_stall", 32'(stall), 1);
    put(itype(6'h04, 1, 0, 16'd4)); mid();
    chk("ori_beq_release", 32'(stall), 0);
    chk("ori_beq_D_rs", 32'(fwd_D_rs), 2);
    chk("ori_beq_D_rt", 32'(fwd_D_rt), 0);
    flush();

    // addu $4,$2,$3 ; nop ; beq $4,$4
    put(rtype(2, 3, 4, 6'h21));
    put(NOP);
    put(itype(6'h04, 4, 4, 16'd2)); mid();
    chk("addu_nop_beq_stall", 32'(stall), 0);
    chk("addu_nop_beq_D_rs", 32'(fwd_D_rs), 2);
    chk("addu_nop_beq_D_rt", 32'(fwd_D_rt), 2);
    flush();

    // jal ; jr $31
    put({6'h03, 26'h40});
    put(rtype(31, 0, 0, 6'h08)); mid();
    chk("jal_jr_stall", 32'(stall), 0);
    chk("jal_jr_D_rs", 32'(fwd_D_rs), 1);
    flush();

    // writes to $0 never forward or stall
    put(rtype(1, 1, 0, 6'h21));
    put(rtype(0, 0, 3, 6'h21)); mid();
    chk("zero_reg_stall", 32'(stall), 0);
    chk("zero_reg_fwd", 32'({fwd_D_rs, fwd_D_rt}), 0);
    flush();

    // lw $5 ; sw $5,0($0)
    put(itype(6'h23, 0, 5, 16'd0));
    put(itype(6'h2b, 0, 5, 16'd0)); mid();
    chk("lw_sw_stall", 32'(stall), 0);
    put(NOP); mid();
    chk("lw_sw_E_rt", 32'(fwd_E_rt), 0);
    put(NOP); mid();
    chk("lw_sw_M_rt", 32'(fwd_M_rt), 3);
    flush();

    // reset while lw in E and dependent addu in D
    put(itype(6'h23, 0, 1, 16'd0));
    put(rtype(1, 1, 2, 6'h21));
    reset = 1'b1;
    mid();
    chk("rst_mid_pre_stall", 32'(stall), 1);
    put(rtype(1, 1, 2, 6'h21));
    reset = 1'b0;
    mid();
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_fwd", 32'({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}), 0);
    flush();

    // mult $1,$2 ; mflo $3
    put(rtype(1, 2, 0, 6'h18)); mid();
    chk("mult_nostall", 32'(stall), 0);
    put(rtype(0, 0, 3, 6'h12)); mid();
    n_st = 0; n_bz = 0;
    for (int i = 0; i < 40 && stall === 1'b1; i++) begin
      n_st++;
      if (md_busy === 1'b1) n_bz++;
      put(rtype(0, 0, 3, 6'h12)); mid();
    end
`ifdef HAZARD_MD_EN
    chk("md_stall_cycles", 32'(n_st), 32'(MULT_CYC + 1));
    chk("md_busy_cycles", 32'(n_bz), 32'(MULT_CYC));
`else
    chk("md_stall_cycles", 32'(n_st), 0);
    chk("md_busy_cycles", 32'(n_bz), 0);
`endif
    chk("md_release", 32'(stall), 0);
    flush();

    // randomized traffic; a stalled instruction stays in D
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      if (!last_stall) D_instr = rand_instr();
    end
    reset = 1'b0;
    repeat (12) put(NOP);
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
